// File: rtl/mdu_divider.sv
// mdu_divider: multi-cycle 32-bit radix-2 restoring divider for the EXE stage.
// Handles OP_DIV (signed) and OP_DIVU (unsigned), producing quotient (LO) and
// remainder (HI). The state machine runs IDLE -> CALC (32 steps) -> DONE.
// Optional feature macro: DIV_FAST_PATH_EN. When it is defined, a divide by
// zero or |dividend| < |divisor| skips CALC and completes in one cycle.
module mdu_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] dq;        // dividend bits shifting out / quotient bits shifting in
  logic [31:0] rem;       // partial remainder
  logic [31:0] dvsr;      // |divisor|
  logic        qsign;     // negate the quotient on completion
  logic        rsign;     // negate the remainder on completion
  logic [5:0]  step_cnt;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        a_neg;
  logic        b_neg;
  logic        div_zero;
  logic [32:0] partial;
  logic        step_ok;
  logic [31:0] rem_nxt;
  logic [31:0] dq_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Operand magnitudes and one restoring step, plus the final sign fixup.
  // NOTE: every always_comb output gets a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    a_neg    = div_signed & dividend[31];
    b_neg    = div_signed & divisor[31];
    abs_a    = a_neg ? (32'd0 - dividend) : dividend;
    abs_b    = b_neg ? (32'd0 - divisor) : divisor;
    div_zero = (divisor == 32'd0);

    // rem < dvsr holds throughout, so the 33-bit difference never overflows
    // and bit 32 is a reliable borrow.
    partial  = {rem, dq[31]} - {1'b0, dvsr};
    step_ok  = ~partial[32];
    rem_nxt  = {rem[30:0], dq[31]};
    if (step_ok) begin
      rem_nxt = partial[31:0];
    end
    dq_nxt   = {dq[30:0], step_ok};

    q_fix    = qsign ? (32'd0 - dq_nxt) : dq_nxt;
    r_fix    = rsign ? (32'd0 - rem_nxt) : rem_nxt;
  end

  // Control FSM, iteration datapath and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dq        <= '0;
      rem       <= '0;
      dvsr      <= '0;
      qsign     <= 1'b0;
      rsign     <= 1'b0;
      step_cnt  <= '0;
      div_busy  <= 1'b0;
      div_done  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      // Cancel: back to IDLE, no done pulse, results untouched.
      state    <= IDLE;
      div_busy <= 1'b0;
      div_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_done <= 1'b0;
          if (div_start) begin
            dq       <= abs_a;
            rem      <= '0;
            dvsr     <= abs_b;
            // With a zero divisor the iteration yields q = all ones and
            // r = |dividend|; forcing qsign low and keeping rsign = sign(a)
            // turns that into FFFF_FFFF / dividend-as-presented.
            qsign    <= (a_neg ^ b_neg) & ~div_zero;
            rsign    <= a_neg;
            step_cnt <= '0;
`ifdef DIV_FAST_PATH_EN
            if (div_zero) begin
              quotient  <= 32'hFFFF_FFFF;
              remainder <= dividend;
              div_done  <= 1'b1;
              state     <= DONE;
            end else if (abs_a < abs_b) begin
              quotient  <= '0;
              remainder <= dividend;
              div_done  <= 1'b1;
              state     <= DONE;
            end else begin
              div_busy <= 1'b1;
              state    <= CALC;
            end
`else
            div_busy <= 1'b1;
            state    <= CALC;
`endif
          end
        end

        CALC: begin
          dq       <= dq_nxt;
          rem      <= rem_nxt;
          step_cnt <= step_cnt + 6'd1;
          if (step_cnt == 6'd31) begin
            // Last step: register the sign-corrected results directly.
            quotient  <= q_fix;
            remainder <= r_fix;
            div_busy  <= 1'b0;
            div_done  <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          div_done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          div_busy <= 1'b0;
          div_done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_divider.sv
// tb_mdu_divider: directed self-checking bench for mdu_divider.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge. Cycle n is the interval following rising edge n-1, where edge 0 is
// the one that accepts the start.
module tb_mdu_divider;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        div_busy;
  logic        div_done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int compared   = 0;
  int mismatched = 0;

`ifdef DIV_FAST_PATH_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = 33;
`endif

  mdu_divider dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run one divide; intrude != 0 pulses div_start with other operands in
  // that cycle, which must be ignored.
  task automatic run_op(input string name, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input int lat, input int intrude);
    int done_cyc;
    done_cyc = 0;
    @(negedge clk);
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    div_start  = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (intrude != 0 && c == intrude) begin
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd9;
        divisor    = 32'd3;
      end else begin
        div_start = 1'b0;
      end
      compared++;
      if (div_busy !== (c < lat)) begin
        mismatched++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, c, div_busy, (c < lat));
      end
      if (div_done === 1'b1) done_cyc = c;
    end
    div_start = 1'b0;
    compared++;
    if (done_cyc != lat) begin
      mismatched++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, lat);
    end
    compared++;
    if (quotient !== exp_q) begin
      mismatched++;
      $display("FAIL %s quotient: got %h want %h", name, quotient, exp_q);
    end
    compared++;
    if (remainder !== exp_r) begin
      mismatched++;
      $display("FAIL %s remainder: got %h want %h", name, remainder, exp_r);
    end
    @(negedge clk);
    compared++;
    if (div_done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s done_width: got %b want 0", name, div_done);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    flush      = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({div_busy, div_done} !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_flags: got %b want 00", {div_busy, div_done});
    end
    compared++;
    if (quotient !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_quotient: got %h want 0", quotient);
    end
    compared++;
    if (remainder !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_remainder: got %h want 0", remainder);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    // DIVU 100/7 with an ignored start in cycle 5.
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 5);
  endtask

  task automatic test_signed();
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 0);
    run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 33, 0);
  endtask

  task automatic test_boundaries();
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 0);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run_op("divu_1234_0", 1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, FAST_LAT, 0);
    run_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, FAST_LAT, 0);
    run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, FAST_LAT, 0);
    run_op("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, FAST_LAT, 0);
    // Ends with results 0xFFFF_FFFD / 1 for the flush test.
    run_op("div_7_m2_again", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 0);
  endtask

  task automatic test_flush();
    int done_cyc;
    done_cyc = 0;
    @(negedge clk);
    div_signed = 1'b0;
    dividend   = 32'd50;
    divisor    = 32'd3;
    div_start  = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 10) flush = 1'b1;
    end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);  // cycle 11
    compared++;
    if ({div_busy, div_done} !== 2'b00) begin
      mismatched++;
      $display("FAIL flush_flags: got %b want 00", {div_busy, div_done});
    end
    compared++;
    if (quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) begin
      mismatched++;
      $display("FAIL flush_hold: got %h/%h want fffffffd/00000001", quotient, remainder);
    end
    @(negedge clk);  // cycle 12
    div_start = 1'b1;
    @(posedge clk);  // edge 12
    #1 div_start = 1'b0;
    for (int c = 13; c <= 60 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (div_done === 1'b1) done_cyc = c;
    end
    compared++;
    if (done_cyc != 45) begin
      mismatched++;
      $display("FAIL flush_restart_done: got cycle %0d want 45", done_cyc);
    end
    compared++;
    if (quotient !== 32'd16 || remainder !== 32'd2) begin
      mismatched++;
      $display("FAIL flush_restart_result: got %0d/%0d want 16/2", quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid_calc();
    bit seen_done;
    seen_done = 1'b0;
    @(negedge clk);
    div_signed = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    div_start  = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if ({div_busy, div_done} !== 2'b00) begin
      mismatched++;
      $display("FAIL rst_mid_flags: got %b want 00", {div_busy, div_done});
    end
    compared++;
    if (quotient !== 32'd0 || remainder !== 32'd0) begin
      mismatched++;
      $display("FAIL rst_mid_results: got %h/%h want 0/0", quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (div_done === 1'b1 || div_busy === 1'b1) seen_done = 1'b1;
    end
    compared++;
    if (seen_done) begin
      mismatched++;
      $display("FAIL rst_mid_no_done: got activity after reset want none");
    end
    run_op("divu_after_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
  endtask

  initial begin
    test_reset();
    test_start_while_busy();
    test_signed();
    test_boundaries();
    test_flush();
    test_rst_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
